// File: rtl/sfu_pkg.sv
// Shared definitions for the SFU accumulation array: FSM state encoding and
// default widths used by sfu_array and sfu_post.
package sfu_pkg;

  localparam int NUM_CH_DEF     = 4;
  localparam int PSUM_IN_BW_DEF = 18;
  localparam int ACC_BW_DEF     = 24;
  localparam int OUT_BW_DEF     = 16;
  localparam int SHIFT_BW_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } sfu_state_e;

endpackage

// File: rtl/sfu_post.sv
// Per-channel output stage: arithmetic right shift, optional ReLU, then
// saturation of the signed accumulator into the signed OUT_BW range.
module sfu_post
  import sfu_pkg::*;
#(
  parameter int ACC_BW   = ACC_BW_DEF,
  parameter int OUT_BW   = OUT_BW_DEF,
  parameter int SHIFT_BW = SHIFT_BW_DEF
) (
  input  logic signed [ACC_BW-1:0]   acc,
  input  logic        [SHIFT_BW-1:0] shift,
  input  logic                       relu,
  output logic        [OUT_BW-1:0]   data,
  output logic                       sat
);

  localparam logic [OUT_BW-1:0] OUT_MAX = {1'b0, {(OUT_BW-1){1'b1}}};
  localparam logic [OUT_BW-1:0] OUT_MIN = {1'b1, {(OUT_BW-1){1'b0}}};
  localparam logic signed [ACC_BW-1:0] ACC_MAX = ACC_BW'($signed(OUT_MAX));
  localparam logic signed [ACC_BW-1:0] ACC_MIN = ACC_BW'($signed(OUT_MIN));

  logic signed [ACC_BW-1:0] shifted;
  logic signed [ACC_BW-1:0] rectified;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave a value unassigned and infer a latch.
  always_comb begin
    data      = '0;
    sat       = 1'b0;
    shifted   = acc >>> shift;
    rectified = (relu && shifted[ACC_BW-1]) ? '0 : shifted;
    if (rectified > ACC_MAX) begin
      data = OUT_MAX;
      sat  = 1'b1;
    end else if (rectified < ACC_MIN) begin
      data = OUT_MIN;
      sat  = 1'b1;
    end else begin
      data = rectified[OUT_BW-1:0];
    end
  end

endmodule

// File: rtl/sfu_array.sv
// Multi-channel partial-sum accumulator: sums beats of a frame per channel,
// then presents the post-processed result until the consumer takes it.
module sfu_array
  import sfu_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int PSUM_IN_BW = PSUM_IN_BW_DEF,
  parameter int ACC_BW     = ACC_BW_DEF,
  parameter int OUT_BW     = OUT_BW_DEF,
  parameter int SHIFT_BW   = SHIFT_BW_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [NUM_CH*PSUM_IN_BW-1:0] in_psum,
  input  logic                         cfg_simd,
  input  logic                         cfg_relu,
  input  logic [SHIFT_BW-1:0]          cfg_shift,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*OUT_BW-1:0]     out_data,
  output logic [15:0]                  out_beats,
  output logic [NUM_CH-1:0]            out_sat
);

  localparam int HALF_BW = PSUM_IN_BW / 2;

  sfu_state_e state_q, state_d;

  logic                    accept;
  logic                    leave_hold;
  logic                    simd_q, relu_q;
  logic [SHIFT_BW-1:0]     shift_q;
  logic                    eff_simd, eff_relu;
  logic [SHIFT_BW-1:0]     eff_shift;
  logic [15:0]             beats_q, beats_d;
  logic [NUM_CH*OUT_BW-1:0] post_data;
  logic [NUM_CH-1:0]       post_sat;

  assign in_ready   = (state_q != ST_HOLD);
  assign out_valid  = (state_q == ST_HOLD);
  assign accept     = in_valid && in_ready;
  assign leave_hold = (state_q == ST_HOLD) && out_ready;

  // The first beat of a frame must already use its own configuration, so it
  // bypasses the latch; later beats see the latched copy.
  assign eff_simd  = (state_q == ST_IDLE) ? cfg_simd  : simd_q;
  assign eff_relu  = (state_q == ST_IDLE) ? cfg_relu  : relu_q;
  assign eff_shift = (state_q == ST_IDLE) ? cfg_shift : shift_q;

  assign beats_d = (beats_q == 16'hFFFF) ? beats_q : beats_q + 16'd1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = in_last ? ST_HOLD : ST_ACCUM;
      ST_ACCUM: if (accept && in_last) state_d = ST_HOLD;
      ST_HOLD:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: reset is synchronous and tested first, so it overrides any beat or
  // handshake arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PSUM_IN_BW-1:0] psum;
    logic [HALF_BW-1:0]    lane_lo, lane_hi;
    logic [ACC_BW-1:0]     term;
    logic [ACC_BW-1:0]     acc_q, acc_d;

    assign psum    = in_psum[c*PSUM_IN_BW +: PSUM_IN_BW];
    assign lane_lo = psum[HALF_BW-1:0];
    assign lane_hi = psum[PSUM_IN_BW-1:HALF_BW];
    assign term    = eff_simd
                   ? ({{(ACC_BW-HALF_BW){lane_lo[HALF_BW-1]}}, lane_lo}
                    + {{(ACC_BW-HALF_BW){lane_hi[HALF_BW-1]}}, lane_hi})
                   : {{(ACC_BW-PSUM_IN_BW){psum[PSUM_IN_BW-1]}}, psum};
    assign acc_d   = acc_q + term;

    always_ff @(posedge clk) begin
      if (reset || leave_hold) acc_q <= '0;
      else if (accept)         acc_q <= acc_d;
    end

    // Post-processing sees acc_d so the final beat's term is included.
    sfu_post #(
      .ACC_BW   (ACC_BW),
      .OUT_BW   (OUT_BW),
      .SHIFT_BW (SHIFT_BW)
    ) u_post (
      .acc   (acc_d),
      .shift (eff_shift),
      .relu  (eff_relu),
      .data  (post_data[c*OUT_BW +: OUT_BW]),
      .sat   (post_sat[c])
    );
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || leave_hold) begin
      simd_q    <= 1'b0;
      relu_q    <= 1'b0;
      shift_q   <= '0;
      beats_q   <= '0;
      out_data  <= '0;
      out_beats <= '0;
      out_sat   <= '0;
    end else if (accept) begin
      beats_q <= beats_d;
      if (state_q == ST_IDLE) begin
        simd_q  <= cfg_simd;
        relu_q  <= cfg_relu;
        shift_q <= cfg_shift;
      end
      if (in_last) begin
        out_data  <= post_data;
        out_beats <= beats_d;
        out_sat   <= post_sat;
      end
    end
  end

endmodule

// File: tb/tb_sfu_array.sv
// Self-checking bench for sfu_array: directed frames from the requirements
// plus random frames, compared against an integer reference model.
module tb_sfu_array;

  localparam int NUM_CH     = 4;
  localparam int PSUM_IN_BW = 18;
  localparam int ACC_BW     = 24;
  localparam int OUT_BW     = 16;
  localparam int SHIFT_BW   = 4;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_last;
  logic [NUM_CH*PSUM_IN_BW-1:0] in_psum;
  logic                         cfg_simd;
  logic                         cfg_relu;
  logic [SHIFT_BW-1:0]          cfg_shift;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_CH*OUT_BW-1:0]     out_data;
  logic [15:0]                  out_beats;
  logic [NUM_CH-1:0]            out_sat;

  sfu_array #(
    .NUM_CH     (NUM_CH),
    .PSUM_IN_BW (PSUM_IN_BW),
    .ACC_BW     (ACC_BW),
    .OUT_BW     (OUT_BW),
    .SHIFT_BW   (SHIFT_BW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_psum   (in_psum),
    .cfg_simd  (cfg_simd),
    .cfg_relu  (cfg_relu),
    .cfg_shift (cfg_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beats (out_beats),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NUM_CH*PSUM_IN_BW-1:0] frame_q [$];
  logic [NUM_CH*OUT_BW-1:0]     exp_data;
  logic [NUM_CH-1:0]            exp_sat;
  logic [15:0]                  exp_beats;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_CH*PSUM_IN_BW-1:0] rand_beat();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic longint sx(input longint v, input int bits);
    longint half;
    half = 64'sd1 <<< (bits - 1);
    return (v >= half) ? v - 2 * half : v;
  endfunction

  // Reference: integer sums wrapped to ACC_BW, floor-divide by 2^shift,
  // optional clamp at zero, then clamp to the signed OUT_BW range.
  function automatic void model(input bit simd, input bit relu, input int shift,
                                output logic [NUM_CH*OUT_BW-1:0] d,
                                output logic [NUM_CH-1:0] s);
    longint acc [NUM_CH];
    longint v;
    longint lim_hi, lim_lo, mask;
    logic [NUM_CH*PSUM_IN_BW-1:0] beat;
    logic [PSUM_IN_BW-1:0] ch;
    lim_hi = (64'sd1 <<< (OUT_BW - 1)) - 1;
    lim_lo = -(64'sd1 <<< (OUT_BW - 1));
    mask   = (64'sd1 <<< ACC_BW) - 1;
    d = '0;
    s = '0;
    for (int c = 0; c < NUM_CH; c++) acc[c] = 0;
    foreach (frame_q[b]) begin
      beat = frame_q[b];
      for (int c = 0; c < NUM_CH; c++) begin
        ch = beat[c*PSUM_IN_BW +: PSUM_IN_BW];
        if (simd)
          acc[c] = acc[c] + sx(longint'(ch[PSUM_IN_BW/2-1:0]), PSUM_IN_BW/2)
                          + sx(longint'(ch[PSUM_IN_BW-1:PSUM_IN_BW/2]), PSUM_IN_BW/2);
        else
          acc[c] = acc[c] + sx(longint'(ch), PSUM_IN_BW);
        acc[c] = sx(acc[c] & mask, ACC_BW);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      v = acc[c] >>> shift;
      if (relu && v < 0) v = 0;
      if (v > lim_hi) begin
        v = lim_hi;
        s[c] = 1'b1;
      end else if (v < lim_lo) begin
        v = lim_lo;
        s[c] = 1'b1;
      end
      d[c*OUT_BW +: OUT_BW] = v[OUT_BW-1:0];
    end
  endfunction

  // Drives frame_q as one frame; later beats carry random cfg that must be ignored.
  task automatic send_frame(input bit simd, input bit relu, input logic [SHIFT_BW-1:0] shift,
                            input int bubbles);
    int n;
    n = frame_q.size();
    model(simd, relu, int'(shift), exp_data, exp_sat);
    exp_beats = 16'(n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_psum  = frame_q[i];
      in_last  = (i == n - 1);
      if (i == 0) {cfg_simd, cfg_relu, cfg_shift} = {simd, relu, shift};
      else        {cfg_simd, cfg_relu, cfg_shift} = SHIFT_BW'($urandom) + 6'($urandom);
      check("in_ready_accum", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_psum  = rand_beat();
      if (i != n - 1) begin
        check("no_early_valid", out_valid, 1'b0);
        if (i == 0) begin
          repeat (bubbles) begin
            {cfg_simd, cfg_relu, cfg_shift} = 6'($urandom);
            @(posedge clk); #1;
            check("bubble_no_valid", out_valid, 1'b0);
          end
        end
      end
    end
    check("out_valid_lat1", out_valid, 1'b1);
    check("out_data", out_data, exp_data);
    check("out_sat", out_sat, exp_sat);
    check("out_beats", out_beats, exp_beats);
    check("in_ready_hold", in_ready, 1'b0);
  endtask

  // Holds the result for a while with a pending input, then releases it.
  task automatic release_hold(input int hold_cycles);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    in_psum   = rand_beat();
    repeat (hold_cycles) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, exp_data);
      check("hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    check("released_valid", out_valid, 1'b0);
    check("released_ready", in_ready, 1'b1);
    check("released_data", out_data, '0);
    check("released_sat", out_sat, '0);
  endtask

  function automatic logic [NUM_CH*PSUM_IN_BW-1:0] with_ch0(input logic [PSUM_IN_BW-1:0] v);
    logic [NUM_CH*PSUM_IN_BW-1:0] b;
    b = rand_beat();
    b[PSUM_IN_BW-1:0] = v;
    return b;
  endfunction

  initial begin
    logic [NUM_CH*PSUM_IN_BW-1:0] b;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_psum   = '0;
    cfg_simd  = 1'b0;
    cfg_relu  = 1'b0;
    cfg_shift = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_valid", out_valid, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_data", out_data, '0);
    check("rst_beats", out_beats, '0);
    check("rst_sat", out_sat, '0);

    // Non-SIMD 100, -30, 5 with ReLU.
    frame_q = {with_ch0(18'(100)), with_ch0(18'(-30)), with_ch0(18'(5))};
    send_frame(1'b0, 1'b1, 4'd0, 0);
    check("ch0_75", out_data[OUT_BW-1:0], 16'd75);
    check("beats_3", out_beats, 16'd3);
    release_hold(1);

    // SIMD lanes +10 / -20 on every channel, two beats, with and without ReLU.
    b = {NUM_CH{9'(10), 9'(-20)}};
    frame_q = {b, b};
    send_frame(1'b1, 1'b1, 4'd0, 0);
    check("simd_relu_ch0", out_data[OUT_BW-1:0], 16'd0);
    release_hold(0);
    frame_q = {b, b};
    send_frame(1'b1, 1'b0, 4'd0, 0);
    release_hold(0);

    // Saturation at 40000 (positive on ch0, negative on ch1).
    b = rand_beat();
    b[PSUM_IN_BW-1:0]          = 18'(20000);
    b[PSUM_IN_BW +: PSUM_IN_BW] = 18'(-20000);
    frame_q = {b, b};
    send_frame(1'b0, 1'b0, 4'd0, 0);
    check("sat_ch0", out_data[OUT_BW-1:0], 16'd32767);
    check("sat_flag0", out_sat[0], 1'b1);
    release_hold(0);
    frame_q = {b, b};
    send_frame(1'b0, 1'b0, 4'd2, 0);
    check("shift2_ch0", out_data[OUT_BW-1:0], 16'd10000);
    check("shift2_flag0", out_sat[0], 1'b0);
    release_hold(5);

    // Single-beat frame, then a frame with three bubbles.
    frame_q = {with_ch0(18'(7))};
    send_frame(1'b0, 1'b0, 4'd0, 0);
    check("single_ch0", out_data[OUT_BW-1:0], 16'd7);
    check("single_beats", out_beats, 16'd1);
    release_hold(0);
    frame_q = {rand_beat(), rand_beat(), rand_beat()};
    send_frame(1'b0, 1'b0, 4'd3, 3);
    release_hold(1);

    // Accumulator wrap: 70 beats of the largest positive input.
    frame_q.delete();
    repeat (70) frame_q.push_back({NUM_CH{18'h1FFFF}});
    send_frame(1'b0, 1'b0, 4'd15, 0);
    release_hold(0);

    // Reset after two accepted beats discards the partial frame.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_last  = 1'b0;
      in_psum  = rand_beat();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_beats", out_beats, '0);
    frame_q = {rand_beat(), rand_beat()};
    send_frame(1'b0, 1'b0, 4'd1, 1);
    release_hold(0);

    // Random frames.
    for (int f = 0; f < 25; f++) begin
      int n;
      n = $urandom_range(1, 6);
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back(rand_beat());
      send_frame(1'($urandom), 1'($urandom), SHIFT_BW'($urandom), $urandom_range(0, 2));
      release_hold($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
